// File: rtl/controle_tentativas_pkg.sv
// Shared definitions for the attempt controller: state and verdict codes.
// Optional per-guess timeout is enabled by defining TENTATIVAS_TIMEOUT_EN.
package controle_tentativas_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] AGUARDA = 2'd1;
  localparam logic [1:0] ACERTOU = 2'd2;
  localparam logic [1:0] PERDEU  = 2'd3;

  localparam logic [1:0] V_IGUAL  = 2'd0;
  localparam logic [1:0] V_PERTO  = 2'd1;
  localparam logic [1:0] V_ERRADA = 2'd2;

  typedef struct packed {
    logic igual;
    logic perto;
    logic errada;
  } leds_t;

  function automatic logic [1:0] veredito(
    input logic igual,
    input logic ate3
  );
    logic [1:0] v;
    v = V_ERRADA;
    unique case (1'b1)
      igual:   v = V_IGUAL;
      ate3:    v = V_PERTO;
      default: v = V_ERRADA;
    endcase
    return v;
  endfunction

  function automatic leds_t leds_de(input logic [1:0] v);
    leds_t l;
    l = '0;
    unique case (1'b1)
      (v == V_IGUAL): l.igual  = 1'b1;
      (v == V_PERTO): l.perto  = 1'b1;
      default:        l.errada = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/controle_tentativas_if.sv
// Comparator verdict, player controls and round-status outputs
// of the attempt controller, bundled for the display side.
interface controle_tentativas_if #(
  parameter int W_TENT = 3
);
  logic              iniciar;
  logic              confirmar;
  logic              igual;
  logic              ate3;
  logic              errada;
  logic              led_igual;
  logic              led_perto;
  logic              led_errada;
  logic [W_TENT-1:0] tentativas_restantes;
  logic              jogando;
  logic              venceu;
  logic              perdeu;
  logic              estourou;

  modport master (
    output iniciar, confirmar,
    output igual, ate3, errada,
    input  led_igual, led_perto, led_errada,
    input  tentativas_restantes,
    input  jogando, venceu, perdeu, estourou
  );

  modport slave (
    input  iniciar, confirmar,
    input  igual, ate3, errada,
    output led_igual, led_perto, led_errada,
    output tentativas_restantes,
    output jogando, venceu, perdeu, estourou
  );
endinterface

// File: rtl/controle_tentativas_detector_borda.sv
// Registered rising-edge detector for a debounced level input.
// The history flop samples every cycle, so a held level yields one pulse.
module detector_borda (
  input  logic clock,
  input  logic sinal,
  output logic borda
);
  logic sinal_q;

  always_ff @(posedge clock) begin
    sinal_q <= sinal;
  end

  assign borda = sinal & ~sinal_q;
endmodule

// File: rtl/controle_tentativas.sv
// Game-round controller: counts attempts, latches verdict LEDs, win/loss.
// Define TENTATIVAS_TIMEOUT_EN to turn a stalled guess into a wrong attempt.
module controle_tentativas
  import controle_tentativas_pkg::*;
#(
  parameter int MAX_TENTATIVAS = 5,
  parameter int W_TENT         = 3,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input logic                   clock,
  input logic                   reset,
  controle_tentativas_if.slave  bus
);

  if (MAX_TENTATIVAS < 1) begin : g_chk_max
    $error("MAX_TENTATIVAS must be >= 1");
  end
  if ((2 ** W_TENT) <= MAX_TENTATIVAS) begin : g_chk_w
    $error("W_TENT too narrow for MAX_TENTATIVAS");
  end
  if (TIMEOUT_CICLOS < 1) begin : g_chk_to
    $error("TIMEOUT_CICLOS must be >= 1");
  end

  localparam logic [W_TENT-1:0] MAX_T = W_TENT'(MAX_TENTATIVAS);

  logic [1:0]        estado;
  leds_t             leds;
  logic [W_TENT-1:0] restantes;
  logic              borda;
  logic              timeout;
  logic              tenta;
  logic [1:0]        vered;

  detector_borda u_borda (
    .clock (clock),
    .sinal (bus.confirmar),
    .borda (borda)
  );

`ifdef TENTATIVAS_TIMEOUT_EN
  localparam int W_CONT = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [W_CONT-1:0] LIM =
    W_CONT'(TIMEOUT_CICLOS - 1);

  logic [W_CONT-1:0] cont_tempo;
  logic              estourou_r;

  assign timeout = (cont_tempo == LIM) & ~borda;
`else
  assign timeout = 1'b0;
`endif

  // a real guess always beats the timeout, which counts as wrong
  assign tenta = borda | timeout;
  assign vered = borda ? veredito(bus.igual, bus.ate3)
                       : V_ERRADA;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= IDLE;
      leds      <= '0;
      restantes <= MAX_T;
`ifdef TENTATIVAS_TIMEOUT_EN
      cont_tempo <= '0;
      estourou_r <= 1'b0;
`endif
    end else if (bus.iniciar) begin
      estado    <= AGUARDA;
      leds      <= '0;
      restantes <= MAX_T;
`ifdef TENTATIVAS_TIMEOUT_EN
      cont_tempo <= '0;
      estourou_r <= 1'b0;
`endif
    end else if (estado == AGUARDA) begin
      if (tenta) begin
        leds <= leds_de(vered);
`ifdef TENTATIVAS_TIMEOUT_EN
        cont_tempo <= '0;
        estourou_r <= ~borda;
`endif
        if (vered == V_IGUAL) begin
          estado <= ACERTOU;
        end else if (restantes <= W_TENT'(1)) begin
          restantes <= '0;
          estado    <= PERDEU;
        end else begin
          restantes <= restantes - W_TENT'(1);
        end
      end else begin
`ifdef TENTATIVAS_TIMEOUT_EN
        cont_tempo <= cont_tempo + W_CONT'(1);
`endif
      end
    end
  end

  assign bus.led_igual            = leds.igual;
  assign bus.led_perto            = leds.perto;
  assign bus.led_errada           = leds.errada;
  assign bus.tentativas_restantes = restantes;
  assign bus.jogando              = (estado == AGUARDA);
  assign bus.venceu               = (estado == ACERTOU);
  assign bus.perdeu               = (estado == PERDEU);
`ifdef TENTATIVAS_TIMEOUT_EN
  assign bus.estourou             = estourou_r;
`else
  assign bus.estourou             = 1'b0;
`endif

endmodule
